cam_block_capture: RTL and testbench

Parametrised frame grabber for the DVP camera port: crops a configurable window from the pixel stream and box-averages each SCALE×SCALE block down to an IMG_W×IMG_H grid. It binarises each block against a runtime threshold and presents the finished bitmap to the classifier as one atomic vector. It replaces the fixed 28×28 point-sampling grabber between the camera pins and the recognition core.

---
 rtl/cam_pkg.sv | 27 ++
 rtl/cam_sync_edge.sv | 21 ++
 rtl/cam_block_capture.sv | 206 ++++++++++++++++++++
 tb/tb_cam_block_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and elaboration helpers for the DVP block-capture front end.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } cam_state_e;

  localparam logic [7:0] DEF_THRESHOLD = 8'd80;

  // floor(log2(v)); exact for the power-of-two block edges used here
  function automatic int cam_log2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= v) r = i;
    end
    return r;
  endfunction

  function automatic int cam_acc_w(input int pix_w, input int scale);
    return pix_w + 2 * cam_log2(scale);
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera control line and derives same-cycle rise/fall strobes
// by comparing the live input against its registered copy.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/cam_block_capture.sv
// Crops a window from the DVP stream and reduces each SCALE x SCALE block to one
// ink bit. Define CAM_BOXAVG_EN for box averaging; otherwise top-left point sampling.
//
//   state      | meaning
//   IDLE       | waiting for capture_req
//   ARMED      | request accepted, waiting for vsync falling edge
//   CAPTURE    | counting pixels/lines, filling working buffer
//   DONE       | one cycle: done pulse, img_out holds the new bitmap
module cam_block_capture
  import cam_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SCALE = 8,
  parameter int X_OFF = 48,
  parameter int Y_OFF = 8,
  parameter int PIX_W = 8,
  parameter int CNT_W = 11
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [PIX_W-1:0]       d_in,
  input  logic                   capture_req,
  input  logic [PIX_W-1:0]       threshold,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err,
  output logic [IMG_W*IMG_H-1:0] img_out
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SH    = cam_log2(SCALE);
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int X_END = X_OFF + IMG_W * SCALE;
  localparam int Y_END = Y_OFF + IMG_H * SCALE;
  localparam logic [CNT_W-1:0] X_LO  = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0] Y_LO  = CNT_W'(Y_OFF);
  localparam logic [CNT_W-1:0] LMASK = CNT_W'(SCALE - 1);

  cam_state_e state_q, state_d;

  logic vsync_rise, vsync_fall, href_rise, href_fall;
  logic unused_strobes;

  cam_sync_edge u_vsync_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (vsync),
    .rise_o (vsync_rise),
    .fall_o (vsync_fall)
  );

  cam_sync_edge u_href_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (href),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  assign unused_strobes = vsync_rise ^ href_rise;

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [NPIX-1:0]  buf_q, buf_d, img_q, img_d;

  logic [CNT_W-1:0] x_rel, y_rel, col, row, lx, ly;
  logic [IDX_W-1:0] idx;
  logic             in_win, first_px, last_line;

  assign x_rel     = x_q - X_LO;
  assign y_rel     = y_q - Y_LO;
  assign col       = x_rel >> SH;
  assign row       = y_rel >> SH;
  assign lx        = x_rel & LMASK;
  assign ly        = y_rel & LMASK;
  assign idx       = IDX_W'(int'(row) * IMG_W + int'(col));
  assign in_win    = (int'(x_q) >= X_OFF) && (int'(x_q) < X_END) &&
                     (int'(y_q) >= Y_OFF) && (int'(y_q) < Y_END);
  assign first_px  = (lx == '0) && (ly == '0);
  assign last_line = (int'(y_q) == Y_END - 1);

`ifdef CAM_BOXAVG_EN
  localparam int ACC_W = cam_acc_w(PIX_W, SCALE);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [ACC_W-1:0] acc_q [IMG_W];
  logic [ACC_W-1:0] acc_d [IMG_W];
  logic [ACC_W-1:0] sum;
  logic [PIX_W-1:0] avg;
  logic [COL_W-1:0] col_a;
  logic             last_px;

  assign col_a   = COL_W'(col);
  assign last_px = (lx == LMASK) && (ly == LMASK);
`endif

  // FSM: state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; vsync in CAPTURE overrides a coincident href fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (capture_req) state_d = ST_ARMED;
      ST_ARMED:   if (vsync_fall)  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (vsync)                       state_d = ST_ARMED;
        else if (href_fall && last_line) state_d = ST_DONE;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    frame_err = (state_q == ST_CAPTURE) && vsync;
  end

  // Datapath next state
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    thr_d = thr_q;
    buf_d = buf_q;
    img_d = img_q;
`ifdef CAM_BOXAVG_EN
    acc_d = acc_q;
    sum   = '0;
    avg   = '0;
`endif
    case (state_q)
      ST_ARMED: begin
        if (vsync_fall) begin
          x_d   = '0;
          y_d   = '0;
          thr_d = threshold;
          buf_d = '0;
`ifdef CAM_BOXAVG_EN
          for (int i = 0; i < IMG_W; i++) acc_d[i] = '0;
`endif
        end
      end
      ST_CAPTURE: begin
        if (!vsync) begin
          if (href) begin
            x_d = x_q + 1'b1;
            if (in_win) begin
`ifdef CAM_BOXAVG_EN
              // restarting on the block's first pixel drops leftovers of short lines
              sum = (first_px ? '0 : acc_q[col_a]) + ACC_W'(d_in);
              if (last_px) begin
                avg          = PIX_W'(sum >> (2 * SH));
                buf_d[idx]   = (avg < thr_q);
                acc_d[col_a] = '0;
              end else begin
                acc_d[col_a] = sum;
              end
`else
              if (first_px) buf_d[idx] = (d_in < thr_q);
`endif
            end
          end else if (href_fall) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (last_line) img_d = buf_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      thr_q <= PIX_W'(DEF_THRESHOLD);
      buf_q <= '0;
      img_q <= '0;
`ifdef CAM_BOXAVG_EN
      for (int i = 0; i < IMG_W; i++) acc_q[i] <= '0;
`endif
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      thr_q <= thr_d;
      buf_q <= buf_d;
      img_q <= img_d;
`ifdef CAM_BOXAVG_EN
      for (int i = 0; i < IMG_W; i++) acc_q[i] <= acc_d[i];
`endif
    end
  end

  assign img_out = img_q;

endmodule

// File: tb/tb_cam_block_capture.sv
// Directed bench for cam_block_capture on a reduced 4x3 grid of 4x4 blocks.
module tb_cam_block_capture;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 3;
  localparam int SCALE   = 4;
  localparam int X_OFF   = 3;
  localparam int Y_OFF   = 2;
  localparam int PIX_W   = 8;
  localparam int CNT_W   = 6;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int LINE_W  = 24;
  localparam int N_LINES = 16;
  localparam int LAST_Y  = Y_OFF + IMG_H * SCALE - 1;

`ifdef CAM_BOXAVG_EN
  localparam logic [NPIX-1:0] EXP_BLK = 12'h940;
`else
  localparam logic [NPIX-1:0] EXP_BLK = 12'h848;
`endif
  localparam logic [NPIX-1:0] EXP_ONES  = 12'hFFF;
  localparam logic [NPIX-1:0] EXP_ZERO  = 12'h000;
  localparam logic [NPIX-1:0] EXP_CHECK = 12'h5A5;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0;
  logic             href = 1'b0;
  logic [PIX_W-1:0] d_in = '0;
  logic             capture_req = 1'b0;
  logic [PIX_W-1:0] threshold = '0;
  logic             busy, done, frame_err;
  logic [NPIX-1:0]  img_out;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int stable_bad = 0;

  int         mode_g = 0;
  logic [7:0] val_g = '0;
  logic [7:0] thr_mid = '0;
  logic       lat_done = 1'b0;
  logic       lat_busy = 1'b1;

  cam_block_capture #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X_OFF(X_OFF),
    .Y_OFF(Y_OFF), .PIX_W(PIX_W), .CNT_W(CNT_W)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .href        (href),
    .d_in        (d_in),
    .capture_req (capture_req),
    .threshold   (threshold),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err),
    .img_out     (img_out)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [NPIX-1:0] img_prev = '0;
  logic            prev_valid = 1'b0;

  always @(negedge pclk) begin
    if (done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (rst_n && prev_valid && (img_out !== img_prev) && (done !== 1'b1)) stable_bad++;
    img_prev   = img_out;
    prev_valid = rst_n;
  end

  function automatic logic [7:0] pix(input int x, input int y);
    int lx, ly, c, r, idx;
    if (x < X_OFF || x >= X_OFF + IMG_W * SCALE || y < Y_OFF || y >= Y_OFF + IMG_H * SCALE)
      return 8'd0;
    lx  = (x - X_OFF) % SCALE;
    ly  = (y - Y_OFF) % SCALE;
    c   = (x - X_OFF) / SCALE;
    r   = (y - Y_OFF) / SCALE;
    idx = r * IMG_W + c;
    if (mode_g == 0) return val_g;
    if (mode_g == 1) begin
      case (idx)
        6:       return (lx % 2 != 0) ? 8'd255 : 8'd0;
        8:       return (lx % 2 != 0) ? 8'd0 : 8'd255;
        3:       return (lx == 0 && ly == 0) ? 8'd0 : 8'd200;
        11:      return 8'd129;
        0:       return 8'd130;
        default: return 8'd200;
      endcase
    end
    return ((r + c) % 2 != 0) ? 8'd220 : 8'd20;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic request();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  // abort_line: vsync rises together with that line's href fall
  task automatic send_lines(input int abort_line, input int stop_line);
    lat_done = 1'b0;
    lat_busy = 1'b1;
    for (int y = 0; y < N_LINES && y < stop_line; y++) begin
      for (int x = 0; x < LINE_W; x++) begin
        href = 1'b1;
        d_in = pix(x, y);
        tick();
      end
      href = 1'b0;
      d_in = '0;
      if (y == 0) threshold = thr_mid;
      if (y == abort_line) begin
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        return;
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        if (y == LAST_Y && k == 0) lat_done = done;
        if (y == LAST_Y && k == 1) lat_busy = busy;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
    total++; if (img_out !== EXP_ZERO) begin bad++; $display("FAIL reset_img: got %h want %h", img_out, EXP_ZERO); end
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_uniform_ink();
    int d0, e0;
    mode_g = 0; val_g = 8'd40; threshold = 8'd80; thr_mid = 8'd0;
    d0 = done_cnt; e0 = err_cnt;
    capture_req = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_before_req: got %b want 0", busy); end
    tick();
    capture_req = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_req: got %b want 1", busy); end
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ink_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_ONES) begin bad++; $display("FAIL ink_img: got %h want %h", img_out, EXP_ONES); end
    total++; if (lat_done !== 1'b1) begin bad++; $display("FAIL done_latency: got %b want 1", lat_done); end
    total++; if (lat_busy !== 1'b0) begin bad++; $display("FAIL busy_after_done: got %b want 0", lat_busy); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL ink_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_uniform_blank();
    int d0, e0;
    mode_g = 0; val_g = 8'd200; threshold = 8'd80; thr_mid = 8'd255;
    d0 = done_cnt; e0 = err_cnt;
    request();
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL blank_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_ZERO) begin bad++; $display("FAIL blank_img: got %h want %h", img_out, EXP_ZERO); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL blank_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_blocks();
    int d0;
    mode_g = 1; threshold = 8'd130; thr_mid = 8'd130;
    d0 = done_cnt;
    request();
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL blocks_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_BLK) begin bad++; $display("FAIL blocks_img: got %h want %h", img_out, EXP_BLK); end
  endtask

  task automatic test_reset_mid();
    int d0;
    mode_g = 0; val_g = 8'd40; threshold = 8'd80; thr_mid = 8'd80;
    request();
    vsync_pulse();
    send_lines(-1, 6);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", frame_err); end
    total++; if (img_out !== EXP_ZERO) begin bad++; $display("FAIL rstmid_img: got %h want %h", img_out, EXP_ZERO); end
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", busy); end
    request();
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rstmid_fresh_done: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_ONES) begin bad++; $display("FAIL rstmid_fresh_img: got %h want %h", img_out, EXP_ONES); end
  endtask

  task automatic test_abort(input int line, input logic [7:0] val,
                            input logic [NPIX-1:0] prev_img, input logic [NPIX-1:0] new_img);
    int d0, e0;
    mode_g = 0; val_g = val; threshold = 8'd80; thr_mid = 8'd80;
    d0 = done_cnt; e0 = err_cnt;
    request();
    vsync_pulse();
    send_lines(line, 99);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL abort%0d_err_count: got %0d want 1", line, err_cnt - e0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL abort%0d_no_done: got %0d want 0", line, done_cnt - d0); end
    total++; if (img_out !== prev_img) begin bad++; $display("FAIL abort%0d_img_kept: got %h want %h", line, img_out, prev_img); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort%0d_busy: got %b want 1", line, busy); end
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL abort%0d_retry_done: got %0d want 1", line, done_cnt - d0); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL abort%0d_retry_err: got %0d want 1", line, err_cnt - e0); end
    total++; if (img_out !== new_img) begin bad++; $display("FAIL abort%0d_retry_img: got %h want %h", line, img_out, new_img); end
  endtask

  task automatic test_checker();
    int d0;
    mode_g = 2; threshold = 8'd80; thr_mid = 8'd80;
    d0 = done_cnt;
    request();
    tick();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL check_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_CHECK) begin bad++; $display("FAIL check_img: got %h want %h", img_out, EXP_CHECK); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL check_idle: got %b want 0", busy); end
    mode_g = 0; val_g = 8'd40;
    vsync_pulse();
    send_lines(-1, 99);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL norequest_done: got %0d want 1", done_cnt - d0); end
    total++; if (img_out !== EXP_CHECK) begin bad++; $display("FAIL norequest_img: got %h want %h", img_out, EXP_CHECK); end
  endtask

  initial begin
    test_reset();
    test_uniform_ink();
    test_uniform_blank();
    test_blocks();
    test_reset_mid();
    test_abort(7, 8'd200, EXP_ONES, EXP_ZERO);
    test_abort(LAST_Y, 8'd40, EXP_ZERO, EXP_ONES);
    test_checker();
    total++; if (stable_bad != 0) begin bad++; $display("FAIL img_stability: got %0d changes want 0", stable_bad); end
    total++; if (err_cnt != 2) begin bad++; $display("FAIL total_frame_err: got %0d want 2", err_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
